// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver state encoding and word-select polarity.
package i2s_pkg;

    typedef enum logic [1:0] {
        HUNT,
        LEFT,
        RIGHT
    } i2s_rx_state_t;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings sclk/ws/sd into the mclk domain through equal-depth synchronisers
// and flags the mclk cycle on which the synchronised sclk has just risen.
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic mclk,
    input  logic rst,
    input  logic sclk,
    input  logic ws,
    input  logic sd,
    output logic rise,
    output logic ws_sync,
    output logic sd_sync
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] ws_q;
    logic [SYNC_STAGES-1:0] sd_q;
    logic                   sclk_d;

    always_ff @(posedge mclk) begin
        if (rst) begin
            sclk_q <= '0;
            ws_q   <= '0;
            sd_q   <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            ws_q   <= {ws_q[SYNC_STAGES-2:0], ws};
            sd_q   <= {sd_q[SYNC_STAGES-2:0], sd};
            sclk_d <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign rise    = sclk_q[SYNC_STAGES-1] & ~sclk_d;
    assign ws_sync = ws_q[SYNC_STAGES-1];
    assign sd_sync = sd_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver: deserialises MSB-first left/right words in the mclk
// domain and presents each complete stereo pair with a one-cycle strobe.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ws,
    input  logic             sd_rx,
    output logic [WIDTH-1:0] rx_data_l,
    output logic [WIDTH-1:0] rx_data_r,
    output logic             rx_valid,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic             rise;
    logic             ws_sync;
    logic             sd_sync;

    i2s_rx_state_t    state;
    i2s_rx_state_t    next_slot;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] hold_l;
    logic             left_ok;
    logic             ws_last;
    logic             take;
    logic             done;
    logic             ws_chg;

    i2s_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .mclk    (mclk),
        .rst     (rst),
        .sclk    (sclk),
        .ws      (ws),
        .sd      (sd_rx),
        .rise    (rise),
        .ws_sync (ws_sync),
        .sd_sync (sd_sync)
    );

    // Bits past WIDTH leave both counter and shift register untouched.
    always_comb begin
        take       = (cnt < FULL);
        cnt_next   = take ? cnt + CW'(1) : cnt;
        shift_next = take ? {shreg[WIDTH-2:0], sd_sync} : shreg;
        done       = take && (cnt_next == FULL);
        ws_chg     = (ws_sync != ws_last);
        next_slot  = (ws_sync == WS_LEFT) ? LEFT : RIGHT;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state     <= HUNT;
            cnt       <= '0;
            shreg     <= '0;
            hold_l    <= '0;
            left_ok   <= 1'b0;
            ws_last   <= 1'b0;
            rx_data_l <= '0;
            rx_data_r <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (rise) begin
                ws_last <= ws_sync;
                unique case (state)
                    HUNT: begin
                        if (ws_chg) begin
                            state   <= next_slot;
                            cnt     <= '0;
                            left_ok <= 1'b0;
                        end
                    end
                    LEFT, RIGHT: begin
                        cnt   <= cnt_next;
                        shreg <= shift_next;
                        if (done) begin
                            if (state == LEFT) begin
                                hold_l  <= shift_next;
                                left_ok <= 1'b1;
                            end else if (left_ok) begin
                                rx_data_l <= hold_l;
                                rx_data_r <= shift_next;
                                rx_valid  <= 1'b1;
                                left_ok   <= 1'b0;
                            end
                        end
                        // The bit on a ws-change rise is the old slot's last bit.
                        if (ws_chg) begin
                            if (cnt_next < FULL) begin
                                frame_err <= 1'b1;
                                left_ok   <= 1'b0;
                            end
                            cnt   <= '0;
                            state <= next_slot;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: table of stereo frames plus a
// mid-frame reset sequence, checked through a scoreboard of expected pairs.
module tb_i2s_receiver;

    localparam int WIDTH = 16;
    localparam int SYNC  = 2;

    logic             mclk;
    logic             rst;
    logic             sclk;
    logic             ws;
    logic             sd_rx;
    logic [WIDTH-1:0] rx_data_l;
    logic [WIDTH-1:0] rx_data_r;
    logic             rx_valid;
    logic             frame_err;

    i2s_receiver #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .mclk      (mclk),
        .rst       (rst),
        .sclk      (sclk),
        .ws        (ws),
        .sd_rx     (sd_rx),
        .rx_data_l (rx_data_l),
        .rx_data_r (rx_data_r),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    typedef struct {
        int unsigned half;
        int unsigned lbits;
        int unsigned rbits;
        logic [15:0] l;
        logic [15:0] r;
        int unsigned exp_valid;
        int unsigned exp_err;
    } vec_t;

    int           tests;
    int           failed;
    int unsigned  cyc;
    int unsigned  last_rise_cyc;
    int unsigned  valid_cnt;
    int unsigned  err_cnt;
    int unsigned  stab_viol;
    logic         prev_valid;
    logic [15:0]  last_l;
    logic [15:0]  last_r;
    logic [31:0]  sb[$];

    initial begin
        tests = 0; failed = 0; cyc = 0; last_rise_cyc = 0;
        valid_cnt = 0; err_cnt = 0; stab_viol = 0;
        prev_valid = 1'b0; last_l = '0; last_r = '0;
    end

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each strobe, tracks latency and holding.
    always @(negedge mclk) begin
        if (rst) begin
            last_l = '0;
            last_r = '0;
            prev_valid = 1'b0;
        end else begin
            if (frame_err) err_cnt++;
            if (rx_valid) begin
                valid_cnt++;
                tests++;
                if (sb.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_valid: got %h_%h expected no pair", rx_data_l, rx_data_r);
                end else begin
                    logic [31:0] exp;
                    exp = sb.pop_front();
                    if ({rx_data_l, rx_data_r} !== exp) begin
                        failed++;
                        $display("FAIL pair: got %h_%h expected %h_%h", rx_data_l, rx_data_r, exp[31:16], exp[15:0]);
                    end
                end
                tests++;
                if (cyc - last_rise_cyc < 1 || cyc - last_rise_cyc > SYNC + 2) begin
                    failed++;
                    $display("FAIL latency: got %0d expected 1..%0d", cyc - last_rise_cyc, SYNC + 2);
                end
                if (prev_valid) stab_viol++;
                last_l = rx_data_l;
                last_r = rx_data_r;
            end else if (rx_data_l !== last_l || rx_data_r !== last_r) begin
                stab_viol++;
            end
            prev_valid = rx_valid;
        end
    end

    task automatic drive_bit(input logic ws_v, input logic sd_v, input int unsigned half);
        ws    = ws_v;
        sd_rx = sd_v;
        repeat (half) @(negedge mclk);
        sclk = 1'b1;
        last_rise_cyc = cyc;
        repeat (half) @(negedge mclk);
        sclk = 1'b0;
    endtask

    // ws leads data by one bit, so a slot's last bit carries the next slot's ws.
    task automatic send_slot(input logic [15:0] w, input int unsigned start, input int unsigned nbits,
                             input logic ws_v, input logic ws_end, input int unsigned half);
        for (int unsigned i = 0; i < nbits; i++) begin
            int unsigned idx;
            logic b;
            idx = start + i;
            b = (idx < 16) ? w[15 - idx] : 1'b0;
            drive_bit((i == nbits - 1) ? ws_end : ws_v, b, half);
        end
    endtask

    task automatic send_frame(input vec_t v);
        if (v.exp_valid != 0) sb.push_back({v.l, v.r});
        send_slot(v.l, 0, v.lbits, 1'b0, 1'b1, v.half);
        send_slot(v.r, 0, v.rbits, 1'b1, 1'b0, v.half);
        repeat (4) @(negedge mclk);
    endtask

    task automatic run_frame(input string name, input vec_t v);
        int unsigned v0;
        int unsigned e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(v);
        check({name, "_valid"}, valid_cnt - v0, v.exp_valid);
        check({name, "_err"}, err_cnt - e0, v.exp_err);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[11];

    initial begin
        vec_t v;
        int unsigned v0;
        int unsigned e0;

        vecs[0]  = '{12, 16, 16, 16'hFFFF, 16'h1111, 0, 0};
        vecs[1]  = '{12, 16, 16, 16'hFFFF, 16'h1111, 1, 0};
        vecs[2]  = '{12, 16, 16, 16'hA5A5, 16'h5A5A, 1, 0};
        vecs[3]  = '{12, 16, 16, 16'h0001, 16'h8000, 1, 0};
        vecs[4]  = '{12, 16, 16, 16'h0000, 16'hFFFF, 1, 0};
        vecs[5]  = '{12, 16, 16, 16'h1234, 16'hABCD, 1, 0};
        vecs[6]  = '{12, 24, 24, 16'hBEEF, 16'hCAFE, 1, 0};
        vecs[7]  = '{12, 10, 16, 16'h1357, 16'h2468, 0, 1};
        vecs[8]  = '{12, 16, 16, 16'hC3C3, 16'h3C3C, 1, 0};
        vecs[9]  = '{3,  16, 16, 16'hFFFF, 16'h1111, 1, 0};
        vecs[10] = '{3,  16, 16, 16'h1234, 16'hABCD, 1, 0};

        rst = 1'b1; sclk = 1'b0; ws = 1'b0; sd_rx = 1'b0;
        repeat (5) @(negedge mclk);
        check("rst_data_l", 32'(rx_data_l), 32'h0);
        check("rst_data_r", 32'(rx_data_r), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        #1 rst = 1'b0;
        repeat (4) @(negedge mclk);

        for (int i = 0; i < 11; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a right slot; the interrupted frame is never reported.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_slot(16'h9999, 0, 16, 1'b0, 1'b1, 12);
        send_slot(16'h7777, 0, 8, 1'b1, 1'b1, 12);
        @(negedge mclk);
        #1 rst = 1'b1;
        @(negedge mclk);
        check("midrst_data_l", 32'(rx_data_l), 32'h0);
        check("midrst_data_r", 32'(rx_data_r), 32'h0);
        check("midrst_valid", 32'(rx_valid), 32'h0);
        check("midrst_err", 32'(frame_err), 32'h0);
        #1 rst = 1'b0;
        // Remainder of the right slot: HUNT locks on its ws edge, then the slot ends short.
        send_slot(16'h7777, 8, 8, 1'b1, 1'b0, 12);
        repeat (4) @(negedge mclk);
        check("midrst_no_valid", valid_cnt - v0, 0);
        check("midrst_short_err", err_cnt - e0, 1);

        v = '{12, 16, 16, 16'h0F0F, 16'hF0F0, 1, 0};
        run_frame("post_rst_a", v);
        v = '{12, 16, 16, 16'h55AA, 16'hAA55, 1, 0};
        run_frame("post_rst_b", v);

        check("hold_and_pulse_width", stab_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
